// File: rtl/apb_reg_bridge.sv
// APB3 slave to register-bus master: write pready at T+2, read at T+2+slave delay, timeout as pslverr.
// Optional APB_REG_BRIDGE_ADDR_CHK_EN rejects paddr > ADDR_LIMIT without touching the register bus.
module apb_reg_bridge #(
   parameter int                ADDR_W         = 32,
   parameter int                DATA_W         = 32,
   parameter int                TIMEOUT_CYCLES = 16,
   parameter logic [ADDR_W-1:0] ADDR_LIMIT     = ADDR_W'(32'h0000_00FF)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [DATA_W-1:0] pwdata,
   output logic [DATA_W-1:0] prdata,
   output logic              pready,
   output logic              pslverr,
   output logic              addr_en,
   output logic              rw_direction,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rdata,
   input  logic              rvalid
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

   localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

`ifdef APB_REG_BRIDGE_ADDR_CHK_EN
   localparam bit ADDR_CHK = 1'b1;
`else
   localparam bit ADDR_CHK = 1'b0;
`endif

   state_t     state;
   logic [7:0] tmo_cnt;
   logic       addr_bad;

   assign addr_bad = ADDR_CHK && (paddr > ADDR_LIMIT);

   // pready/pslverr/addr_en default low so each is a single-cycle pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         tmo_cnt      <= '0;
         prdata       <= '0;
         pready       <= 1'b0;
         pslverr      <= 1'b0;
         addr_en      <= 1'b0;
         rw_direction <= 1'b0;
         addr         <= '0;
         wdata        <= '0;
      end else begin
         addr_en <= 1'b0;
         pready  <= 1'b0;
         pslverr <= 1'b0;
         case (state)
            IDLE: begin
               if (psel && penable) begin
                  addr         <= paddr;
                  wdata        <= pwdata;
                  rw_direction <= pwrite;
                  if (addr_bad) begin
                     state   <= DONE;
                     pready  <= 1'b1;
                     pslverr <= 1'b1;
                     if (!pwrite) prdata <= '0;
                  end else begin
                     state   <= ISSUE;
                     addr_en <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (rw_direction) begin
                  state  <= DONE;
                  pready <= 1'b1;
               end else begin
                  tmo_cnt <= '0;
                  state   <= WAIT_RD;
               end
            end
            WAIT_RD: begin
               // rvalid takes priority over a timeout landing in the same cycle.
               if (rvalid) begin
                  prdata <= rdata;
                  pready <= 1'b1;
                  state  <= DONE;
               end else if (tmo_cnt + 8'd1 == TIMEOUT_LIM) begin
                  prdata  <= '0;
                  pready  <= 1'b1;
                  pslverr <= 1'b1;
                  state   <= DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Randomized self-checking bench for apb_reg_bridge against a latency/memory reference model.
module tb_apb_reg_bridge;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int TO     = 16;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [ADDR_W-1:0] paddr = '0;
   logic [DATA_W-1:0] pwdata = '0;
   logic [DATA_W-1:0] prdata;
   logic              pready, pslverr, addr_en, rw_direction;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata = '0;
   logic              rvalid = 1'b0;

   apb_reg_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset_n(reset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
      .addr_en(addr_en), .rw_direction(rw_direction), .addr(addr), .wdata(wdata),
      .rdata(rdata), .rvalid(rvalid)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Register-bus slave: answers reads slave_d cycles after addr_en (-1 = never).
   logic [DATA_W-1:0] slave_mem [logic [ADDR_W-1:0]];
   int                slave_d = 1;
   int                resp_cnt = -1;
   logic [DATA_W-1:0] resp_data = '0;
   bit                stray_req = 1'b0;

   initial begin
      forever begin
         @(posedge clk); #1;
         rvalid = 1'b0;
         rdata  = $urandom;
         if (!reset_n) resp_cnt = -1;
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
               rvalid   = 1'b1;
               rdata    = resp_data;
               resp_cnt = -1;
            end
         end
         if (stray_req) begin
            rvalid    = 1'b1;
            rdata     = 32'hAAAA_AAAA;
            stray_req = 1'b0;
         end
         if (addr_en) begin
            if (rw_direction) slave_mem[addr] = wdata;
            else if (slave_d == 0) begin
               rvalid = 1'b1;
               rdata  = slave_mem.exists(addr) ? slave_mem[addr] : '0;
            end else if (slave_d > 0) begin
               resp_cnt  = slave_d;
               resp_data = slave_mem.exists(addr) ? slave_mem[addr] : '0;
            end
         end
      end
   end

   // Reference model: what the master should observe, from the bridge's contract.
   logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
   logic [DATA_W-1:0] last_rd = '0;

   function automatic bit m_reject(input logic [ADDR_W-1:0] a);
`ifdef APB_REG_BRIDGE_ADDR_CHK_EN
      return a > 32'h0000_00FF;
`else
      return (a === 32'hx);
`endif
   endfunction

   function automatic int m_lat(input bit wr, input logic [ADDR_W-1:0] a, input int dly);
      if (m_reject(a)) return 1;
      if (wr) return 2;
      if (dly >= 1 && dly <= TO) return dly + 2;
      return TO + 2;
   endfunction

   function automatic bit m_err(input bit wr, input logic [ADDR_W-1:0] a, input int dly);
      if (m_reject(a)) return 1'b1;
      if (wr) return 1'b0;
      return !(dly >= 1 && dly <= TO);
   endfunction

   function automatic logic [DATA_W-1:0] m_rdata(input logic [ADDR_W-1:0] a, input int dly);
      if (m_reject(a) || !(dly >= 1 && dly <= TO)) return '0;
      return ref_mem.exists(a) ? ref_mem[a] : '0;
   endfunction

   // Results of the last APB transfer.
   int                r_lat, r_ae_cnt, r_ae_k, r_done;
   logic [DATA_W-1:0] r_rd, r_ae_wdata;
   logic [ADDR_W-1:0] r_ae_addr;
   logic              r_err, r_ae_rw;

   task automatic apb_xfer(input bit wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input int dly);
      slave_d  = dly;
      r_lat    = 0;
      r_ae_cnt = 0;
      r_ae_k   = -1;
      r_rd     = 'x;
      r_err    = 1'bx;
      r_done   = -1;
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
      @(posedge clk); #1;
      penable = 1'b1;
      while (r_lat < 100) begin
         @(posedge clk); #1;
         r_lat++;
         if (addr_en) begin
            r_ae_cnt++;
            r_ae_k     = r_lat;
            r_ae_addr  = addr;
            r_ae_wdata = wdata;
            r_ae_rw    = rw_direction;
         end
         if (pready) begin
            r_rd   = prdata;
            r_err  = pslverr;
            r_done = cyc;
            break;
         end
      end
      psel = 1'b0; penable = 1'b0;
      if (wr && !m_reject(a)) ref_mem[a] = d;
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({prdata, pready, pslverr, addr_en, rw_direction, addr, wdata} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got pready=%b addr_en=%b addr=%h prdata=%h, want all 0",
                  pready, addr_en, addr, prdata);
      end
      @(negedge clk) reset_n = 1'b1;
   endtask

   task automatic test_write;
      apb_xfer(1'b1, 32'h0, 32'h0000_1234, 1);
      checks++;
      if (r_lat !== 2 || r_err !== 1'b0) begin
         errors++; $display("FAIL write_latency: lat=%0d err=%b, want 2/0", r_lat, r_err);
      end
      checks++;
      if (r_ae_cnt !== 1 || r_ae_k !== 1) begin
         errors++; $display("FAIL write_addr_en: count=%0d at=%0d, want 1 at 1", r_ae_cnt, r_ae_k);
      end
      checks++;
      if (r_ae_rw !== 1'b1 || r_ae_addr !== 32'h0 || r_ae_wdata !== 32'h1234) begin
         errors++;
         $display("FAIL write_cmd: rw=%b addr=%h wdata=%h, want 1/0/1234", r_ae_rw, r_ae_addr, r_ae_wdata);
      end
   endtask

   task automatic test_read;
      apb_xfer(1'b0, 32'h0, '0, 1);
      last_rd = 32'h1234;
      checks++;
      if (r_lat !== 3 || r_err !== 1'b0 || r_rd !== 32'h1234) begin
         errors++;
         $display("FAIL read_basic: lat=%0d err=%b prdata=%h, want 3/0/1234", r_lat, r_err, r_rd);
      end
      checks++;
      if (r_ae_cnt !== 1 || r_ae_k !== 1 || r_ae_rw !== 1'b0) begin
         errors++;
         $display("FAIL read_cmd: count=%0d at=%0d rw=%b, want 1/1/0", r_ae_cnt, r_ae_k, r_ae_rw);
      end
   endtask

   task automatic test_timeout;
      // Late rvalid at T+20 lands in the next transfer's IDLE and must be dropped.
      apb_xfer(1'b0, 32'h0, '0, 19);
      checks++;
      if (r_lat !== TO + 2 || r_err !== 1'b1 || r_rd !== '0) begin
         errors++;
         $display("FAIL timeout: lat=%0d err=%b prdata=%h, want %0d/1/0", r_lat, r_err, r_rd, TO + 2);
      end
      apb_xfer(1'b0, 32'h0, '0, 1);
      checks++;
      if (r_lat !== 3 || r_err !== 1'b0 || r_rd !== 32'h1234) begin
         errors++;
         $display("FAIL after_timeout: lat=%0d err=%b prdata=%h, want 3/0/1234", r_lat, r_err, r_rd);
      end
      // Response in the last WAIT_RD cycle coincides with the timeout: rvalid wins.
      apb_xfer(1'b0, 32'h0, '0, TO);
      checks++;
      if (r_lat !== TO + 2 || r_err !== 1'b0 || r_rd !== 32'h1234) begin
         errors++;
         $display("FAIL rvalid_vs_timeout: lat=%0d err=%b prdata=%h, want %0d/0/1234", r_lat, r_err, r_rd, TO + 2);
      end
      // Response in the ISSUE cycle is stray.
      apb_xfer(1'b0, 32'h0, '0, 0);
      last_rd = '0;
      checks++;
      if (r_lat !== TO + 2 || r_err !== 1'b1 || r_rd !== '0) begin
         errors++;
         $display("FAIL issue_rvalid: lat=%0d err=%b prdata=%h, want %0d/1/0", r_lat, r_err, r_rd, TO + 2);
      end
   endtask

   task automatic test_reset_mid;
      int seen;
      slave_d = -1;
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h8;
      @(posedge clk); #1;
      penable = 1'b1;
      repeat (5) @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      checks++;
      if ({prdata, pready, pslverr, addr_en, rw_direction, addr, wdata} !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs: pready=%b addr=%h rw=%b, want all 0", pready, addr, rw_direction);
      end
      psel = 1'b0; penable = 1'b0;
      @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      last_rd = '0;
      seen = 0;
      repeat (TO + 4) begin
         @(posedge clk); #1;
         if (pready || addr_en || pslverr) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++; $display("FAIL reset_abandon: %0d cycles with activity, want 0", seen);
      end
      apb_xfer(1'b1, 32'h20, 32'hCAFE_0001, 1);
      checks++;
      if (r_lat !== 2 || r_err !== 1'b0 || r_ae_cnt !== 1) begin
         errors++;
         $display("FAIL write_after_reset: lat=%0d err=%b addr_en=%0d, want 2/0/1", r_lat, r_err, r_ae_cnt);
      end
   endtask

   task automatic test_stray;
      apb_xfer(1'b1, 32'h10, 32'h0000_5555, 1);
      @(posedge clk); #1;
      stray_req = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (prdata !== last_rd) begin
         errors++; $display("FAIL stray_capture: prdata=%h, want %h", prdata, last_rd);
      end
      apb_xfer(1'b0, 32'h10, '0, 1);
      last_rd = 32'h5555;
      checks++;
      if (r_rd !== 32'h5555 || r_err !== 1'b0 || r_lat !== 3) begin
         errors++;
         $display("FAIL stray_then_read: prdata=%h err=%b lat=%0d, want 5555/0/3", r_rd, r_err, r_lat);
      end
   endtask

   task automatic test_back_to_back;
      int prev;
      apb_xfer(1'b1, 32'h30, 32'h1, 1);
      prev = r_done;
      for (int i = 0; i < 3; i++) begin
         apb_xfer(1'b1, 32'h34 + 4 * i, $urandom, 1);
         checks++;
         if (r_done - prev !== 4 || r_lat !== 2) begin
            errors++;
            $display("FAIL back_to_back[%0d]: spacing=%0d lat=%0d, want 4/2", i, r_done - prev, r_lat);
         end
         prev = r_done;
      end
   endtask

   task automatic test_addr_limit;
`ifdef APB_REG_BRIDGE_ADDR_CHK_EN
      apb_xfer(1'b1, 32'h100, 32'hDEAD_BEEF, 1);
      checks++;
      if (r_lat !== 1 || r_err !== 1'b1 || r_ae_cnt !== 0) begin
         errors++;
         $display("FAIL addr_chk_write: lat=%0d err=%b addr_en=%0d, want 1/1/0", r_lat, r_err, r_ae_cnt);
      end
      apb_xfer(1'b0, 32'h104, '0, 1);
      checks++;
      if (r_lat !== 1 || r_err !== 1'b1 || r_rd !== '0 || r_ae_cnt !== 0) begin
         errors++;
         $display("FAIL addr_chk_read: lat=%0d err=%b prdata=%h addr_en=%0d, want 1/1/0/0",
                  r_lat, r_err, r_rd, r_ae_cnt);
      end
`else
      apb_xfer(1'b1, 32'h100, 32'hDEAD_BEEF, 1);
      checks++;
      if (r_lat !== 2 || r_err !== 1'b0 || r_ae_cnt !== 1 || r_ae_addr !== 32'h100) begin
         errors++;
         $display("FAIL addr_forward: lat=%0d err=%b addr_en=%0d addr=%h, want 2/0/1/100",
                  r_lat, r_err, r_ae_cnt, r_ae_addr);
      end
`endif
   endtask

   task automatic test_random;
      for (int n = 0; n < 40; n++) begin
         bit                wr;
         logic [ADDR_W-1:0] a;
         logic [DATA_W-1:0] d;
         logic [DATA_W-1:0] exp_rd;
         int                dly, r, exp_lat;
         bit                exp_err;
         wr  = $urandom_range(0, 1);
         a   = 32'($urandom_range(0, 15) * 4);
         d   = $urandom;
         r   = $urandom_range(0, 21);
         dly = (r == 21) ? -1 : r;
         exp_lat = m_lat(wr, a, dly);
         exp_err = m_err(wr, a, dly);
         exp_rd  = m_rdata(a, dly);
         apb_xfer(wr, a, d, dly);
         checks++;
         if (r_lat !== exp_lat || r_err !== exp_err) begin
            errors++;
            $display("FAIL rand[%0d] wr=%b a=%h dly=%0d: lat=%0d err=%b, want %0d/%b",
                     n, wr, a, dly, r_lat, r_err, exp_lat, exp_err);
         end
         checks++;
         if (r_ae_cnt !== 1 || r_ae_addr !== a || r_ae_rw !== wr || (wr && r_ae_wdata !== d)) begin
            errors++;
            $display("FAIL rand_cmd[%0d]: count=%0d addr=%h rw=%b wdata=%h, want 1/%h/%b/%h",
                     n, r_ae_cnt, r_ae_addr, r_ae_rw, r_ae_wdata, a, wr, d);
         end
         if (!wr) begin
            last_rd = exp_rd;
            checks++;
            if (r_rd !== exp_rd) begin
               errors++;
               $display("FAIL rand_rdata[%0d] a=%h dly=%0d: prdata=%h, want %h", n, a, dly, r_rd, exp_rd);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_reset_mid();
      test_stray();
      test_back_to_back();
      test_addr_limit();
      test_random();
      repeat (25) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/apb_reg_bridge.md
Name: apb_reg_bridge

Overview:
- Upstream master for the simple register-slave bus (addr_en / rw_direction / addr / wdata in; rdata / rvalid out).
- Converts APB3 slave transfers from the SoC interconnect into single-cycle register-bus commands.
- On reads, waits for the slave's rvalid pulse and returns the captured rdata on prdata.
- Bounds every read with a timeout and reports a missing response as pslverr.

Parameters:
- ADDR_W, 32, width of paddr and addr.
- DATA_W, 32, width of pwdata, prdata, wdata and rdata.
- TIMEOUT_CYCLES, 16, maximum WAIT_RD cycles without rvalid before an error response; legal range 1..255.
- ADDR_LIMIT, 32'h0000_00FF, highest legal address; used only when the optional feature is compiled in.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  APB direction, 1 = write.
- paddr  in  ADDR_W  APB address.
- pwdata  in  DATA_W  APB write data.
- prdata  out  DATA_W  APB read data, registered.
- pready  out  1  APB transfer complete, registered, one-cycle pulse.
- pslverr  out  1  APB error; valid only while pready = 1.
- addr_en  out  1  register-bus command strobe, one-cycle pulse.
- rw_direction  out  1  register-bus direction, 1 = write, 0 = read.
- addr  out  ADDR_W  register-bus address.
- wdata  out  DATA_W  register-bus write data.
- rdata  in  DATA_W  register-bus read data; sampled only when rvalid = 1.
- rvalid  in  1  register-bus read-response pulse.

Behaviour:
- Reset, asynchronous, reset_n low:
  - All outputs go to 0; state = IDLE; timeout counter = 0.
  - Reset mid-transfer abandons the transfer. No addr_en, pready or pslverr is emitted for it after reset releases.
- All outputs are driven from flops. There is no combinational path from APB or register-bus inputs to any output.
- FSM states: IDLE, ISSUE, WAIT_RD, DONE.
- IDLE:
  - On psel & penable, capture paddr → addr, pwdata → wdata, pwrite → rw_direction. Go to ISSUE.
  - A setup phase alone (psel = 1, penable = 0) causes no action.
- ISSUE:
  - addr_en = 1 for exactly this cycle.
  - Write: next state DONE with pslverr = 0.
  - Read: clear the timeout counter; next state WAIT_RD.
- WAIT_RD:
  - Each cycle with rvalid = 1: capture rdata → prdata; next state DONE with pslverr = 0.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES, set prdata = 0; next state DONE with pslverr = 1.
  - rvalid and timeout in the same cycle: rvalid wins, no error.
- DONE:
  - pready = 1 for one cycle; pslverr as set on entry.
  - addr, wdata and rw_direction hold their captured values.
  - Next state IDLE.
- Latency, counted from the first APB access cycle T:
  - Write: addr_en in T+1, pready in T+2.
  - Read, when the slave answers one cycle after addr_en: addr_en in T+1, rvalid in T+2, pready and prdata in T+3.
  - Timed-out read: pready in T+2+TIMEOUT_CYCLES.
- Stray rvalid: rvalid seen in IDLE, ISSUE or DONE is ignored. rdata is not captured and no error is raised.
- rvalid after a timeout belongs to an aborted read and is ignored.
- Back-to-back transfers: the master's access phase following DONE is accepted from IDLE. Sustained throughput is one transfer per 4 cycles for writes.
- pready stays 0 outside DONE, so the APB master holds psel, penable and the address stable for the whole transfer.

Optional Feature:
- Macro: APB_REG_BRIDGE_ADDR_CHK_EN.
- Defined:
  - In IDLE, an access with paddr > ADDR_LIMIT skips ISSUE and goes directly to DONE with pslverr = 1.
  - No addr_en is generated; prdata = 0 for such reads.
- Undefined: every address is forwarded; ADDR_LIMIT is unused.

Test Plan:
- Write paddr 0x0, pwdata 0x0000_1234 → addr_en one cycle with rw_direction = 1, addr 0x0, wdata 0x1234; pready in T+2; pslverr = 0.
- Read paddr 0x0; slave returns rvalid with rdata 0x0000_1234 one cycle after addr_en → pready in T+3, prdata 0x1234, pslverr = 0.
- Read with no rvalid, TIMEOUT_CYCLES = 16 → pready in T+18 with pslverr = 1 and prdata 0. A late rvalid at T+20 is ignored and the next read completes normally.
- Assert reset_n low during WAIT_RD, then release → all outputs 0. No pready is emitted for the aborted read, and a new write completes in 2 cycles.
- Stray rvalid with rdata 0xAAAA_AAAA while in IDLE, then a read returning 0x5555 → prdata 0x5555.
- With APB_REG_BRIDGE_ADDR_CHK_EN and ADDR_LIMIT 0xFF, write paddr 0x100 → no addr_en; pready in T+1 with pslverr = 1.
